// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD normalizer: lane-width encodings, FSM states
// and the default datapath width.
package simd_pkg;

  localparam int SIMD_WIDTH_DEFAULT = 256;
  localparam int MAX_LANES          = 32;

  localparam logic [2:0] MODE_8   = 3'd0;
  localparam logic [2:0] MODE_16  = 3'd1;
  localparam logic [2:0] MODE_32  = 3'd2;
  localparam logic [2:0] MODE_64  = 3'd3;
  localparam logic [2:0] MODE_128 = 3'd4;
  localparam logic [2:0] MODE_256 = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Codes 5..7 all select a single full-width lane.
  function automatic logic [2:0] modeIndex(input logic [2:0] mode);
    return (mode > MODE_256) ? MODE_256 : mode;
  endfunction

endpackage

// File: rtl/simd_lane_norm_detect.sv
// Per-lane normalized / zero detection for every supported lane width,
// selected by data_mode. Bits at or above the active lane count read 0.
module simd_lane_norm_detect
  import simd_pkg::*;
#(
  parameter int SIMD_WIDTH = SIMD_WIDTH_DEFAULT
) (
  input  logic [SIMD_WIDTH-1:0] data,
  input  logic [2:0]            data_mode,
  input  logic                  signed_mode,
  output logic [31:0]           norm_o,
  output logic [31:0]           zero_o
);

  logic [6*32-1:0] normAll;
  logic [6*32-1:0] zeroAll;
  logic [2:0]      mIdx;

  for (genvar m = 0; m < 6; m++) begin : gMode
    localparam int LW = 8 << m;
    localparam int NL = SIMD_WIDTH / LW;
    logic [31:0] normV;
    logic [31:0] zeroV;

    // A signed lane of all ones is treated as zero: it has no magnitude to normalize.
    always_comb begin
      normV = '0;
      zeroV = '0;
      for (int l = 0; l < NL; l++) begin
        zeroV[l] = (data[l*LW +: LW] == {LW{1'b0}}) ||
                   (signed_mode && (&data[l*LW +: LW]));
        normV[l] = signed_mode ? (data[l*LW + LW - 1] ^ data[l*LW + LW - 2])
                               : data[l*LW + LW - 1];
      end
    end

    assign normAll[m*32 +: 32] = normV;
    assign zeroAll[m*32 +: 32] = zeroV;
  end

  assign mIdx   = modeIndex(data_mode);
  assign norm_o = normAll[32*int'(mIdx) +: 32];
  assign zero_o = zeroAll[32*int'(mIdx) +: 32];

endmodule

// File: rtl/simd_normalizer.sv
// Iterative SIMD normalizer: shifts every unnormalized lane left one bit per
// cycle until all lanes are normalized or zero, counting shifts per lane.
module simd_normalizer
  import simd_pkg::*;
#(
  parameter int SIMD_WIDTH = SIMD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SIMD_WIDTH-1:0] A,
  input  logic [2:0]            data_mode,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic [SIMD_WIDTH-1:0] out,
  output logic [SIMD_WIDTH-1:0] cnt,
  output logic [31:0]           zero
);

  state_e                      state_q, state_d;
  logic [SIMD_WIDTH-1:0]       data_q, data_d;
  logic [2:0]                  mode_q, mode_d;
  logic                        sign_q, sign_d;
  logic [MAX_LANES-1:0][7:0]   laneCnt_q, laneCnt_d;
  logic [31:0]                 zero_q, zero_d;

  logic [2:0]                  mIdx;
  int                          laneWidth;
  int                          laneCount;
  logic [31:0]                 normVec, zeroVec, laneMask, activeLane;
  logic [SIMD_WIDTH-1:0]       shiftedRaw, bitEn, laneLsb, nextData, cntPacked;
  logic [MAX_LANES-1:0][7:0]   cntInc;
  logic                        allSettled;

  simd_lane_norm_detect #(.SIMD_WIDTH(SIMD_WIDTH)) uDetect (
    .data       (data_q),
    .data_mode  (mode_q),
    .signed_mode(sign_q),
    .norm_o     (normVec),
    .zero_o     (zeroVec)
  );

  assign mIdx       = modeIndex(mode_q);
  assign laneWidth  = 8 << mIdx;
  assign laneCount  = SIMD_WIDTH >> (3 + int'(mIdx));
  assign activeLane = ~normVec & ~zeroVec & laneMask;
  assign allSettled = (activeLane == '0);
  assign shiftedRaw = {data_q[SIMD_WIDTH-2:0], 1'b0};

  always_comb begin
    laneMask = '0;
    for (int l = 0; l < MAX_LANES; l++) laneMask[l] = (l < laneCount);
  end

  // Lane-level shift enables fan out to every bit of their lane; the lane LSB
  // takes zero fill so nothing crosses into the neighbouring lane.
  always_comb begin
    bitEn    = '0;
    laneLsb  = '0;
    nextData = data_q;
    for (int b = 0; b < SIMD_WIDTH; b++) begin
      bitEn[b]   = activeLane[5'(b >> (3 + int'(mIdx)))];
      laneLsb[b] = ((b & (laneWidth - 1)) == 0);
      if (bitEn[b]) nextData[b] = laneLsb[b] ? 1'b0 : shiftedRaw[b];
    end
  end

  always_comb begin
    cntInc = laneCnt_q;
    for (int l = 0; l < MAX_LANES; l++) cntInc[l] = laneCnt_q[l] + {7'b0, activeLane[l]};
  end

  always_comb begin
    cntPacked = '0;
    for (int l = 0; l < MAX_LANES; l++)
      if (l < laneCount) cntPacked[l*laneWidth +: 8] = laneCnt_q[l];
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mode_d    = mode_q;
    sign_d    = sign_q;
    laneCnt_d = laneCnt_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d    = A;
          mode_d    = data_mode;
          sign_d    = signed_mode;
          laneCnt_d = '0;
          zero_d    = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        zero_d = zeroVec & laneMask;
        if (allSettled) begin
          state_d = DONE;
        end else begin
          data_d    = nextData;
          laneCnt_d = cntInc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      mode_q    <= '0;
      sign_q    <= 1'b0;
      laneCnt_q <= '0;
      zero_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      sign_q    <= sign_d;
      laneCnt_q <= laneCnt_d;
      zero_q    <= zero_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign out  = data_q;
  assign cnt  = cntPacked;
  assign zero = zero_q;

endmodule
